// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: 2-bit confidence counter and table entry.
// Tags and targets are held zero-extended to 32 bits so the entry type is parameter-free.
package branch_predictor_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] tag;
        ctr_e            ctr;
        logic [XLEN-1:0] target;
    } entry_t;

    // Jumps are always taken, so they start fully confident.
    function automatic ctr_e ctr_alloc(input logic is_jump);
        return is_jump ? ST : WT;
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Saturating 2-bit counter next-state: step toward ST on taken, toward SNT otherwise.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_e cur,
    input  logic taken,
    output ctr_e nxt
);

    always_comb begin
        nxt = cur;
        unique case (cur)
            SNT: nxt = taken ? WNT : SNT;
            WNT: nxt = taken ? WT  : SNT;
            WT:  nxt = taken ? ST  : WNT;
            ST:  nxt = taken ? ST  : WT;
            default: nxt = cur;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational fetch lookup, EX-stage update,
// mispredict/redirect generation and saturating statistics. Requires PC_W <= 32.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned PC_W    = 9,
    parameter int unsigned ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_taken,
    output logic [31:0]     pred_target,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_is_jump,
    input  logic            ex_taken,
    input  logic [31:0]     ex_target,
    input  logic            ex_pred_taken,
    input  logic [31:0]     ex_pred_target,
    input  logic            flush_tbl,
    output logic            mispredict,
    output logic [31:0]     redirect_pc,
    output logic [31:0]     br_count,
    output logic [31:0]     mp_count
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    entry_t tbl_q [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [XLEN-1:0]  if_tag;
    logic [XLEN-1:0]  ex_tag;
    logic [XLEN-1:0]  ex_tgt_trunc;
    logic [XLEN-1:0]  ex_pc_ext;
    entry_t           if_entry;
    entry_t           ex_entry;
    entry_t           upd_entry;
    logic             if_hit;
    logic             ex_hit;
    logic             upd_en;
    ctr_e             ctr_step;
    logic [31:0]      br_count_q;
    logic [31:0]      mp_count_q;
    logic             unused_if_pc_lo;

    // Instructions are word aligned; the low PC bits never select anything.
    assign unused_if_pc_lo = ^if_pc[1:0];

    assign if_idx       = if_pc[IDX_W+1:2];
    assign ex_idx       = ex_pc[IDX_W+1:2];
    assign if_tag       = XLEN'(if_pc[PC_W-1:IDX_W+2]);
    assign ex_tag       = XLEN'(ex_pc[PC_W-1:IDX_W+2]);
    assign ex_tgt_trunc = XLEN'(ex_target[PC_W-1:0]);
    assign ex_pc_ext    = XLEN'(ex_pc);

    // Lookup reads the registered table directly: same-cycle updates are not bypassed.
    assign if_entry    = tbl_q[if_idx];
    assign ex_entry    = tbl_q[ex_idx];
    assign if_hit      = if_entry.valid && (if_entry.tag == if_tag);
    assign ex_hit      = ex_entry.valid && (ex_entry.tag == ex_tag);
    assign pred_taken  = if_hit && if_entry.ctr[1];
    assign pred_target = if_hit ? if_entry.target : '0;

    sat_counter2 u_sat_counter2 (
        .cur   (ex_entry.ctr),
        .taken (ex_taken),
        .nxt   (ctr_step)
    );

    always_comb begin
        upd_en    = 1'b0;
        upd_entry = ex_entry;
        if (ex_valid) begin
            if (ex_hit) begin
                upd_en = 1'b1;
                if (ex_is_jump) begin
                    upd_entry.ctr    = ST;
                    upd_entry.target = ex_tgt_trunc;
                end else begin
                    upd_entry.ctr = ctr_step;
                    if (ex_taken) begin
                        upd_entry.target = ex_tgt_trunc;
                    end
                end
            end else if (ex_taken) begin
                // Miss on a taken branch evicts whatever shares the index.
                upd_en           = 1'b1;
                upd_entry.valid  = 1'b1;
                upd_entry.tag    = ex_tag;
                upd_entry.ctr    = ctr_alloc(ex_is_jump);
                upd_entry.target = ex_tgt_trunc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= '{valid: 1'b0, tag: '0, ctr: WNT, target: '0};
            end
        end else if (flush_tbl) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tbl_q[i].valid <= 1'b0;
            end
        end else if (upd_en) begin
            tbl_q[ex_idx] <= upd_entry;
        end
    end

    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = '0;
        if (ex_valid) begin
            mispredict  = (ex_taken ^ ex_pred_taken) ||
                          (ex_taken && (ex_target != ex_pred_target));
            redirect_pc = ex_taken ? ex_target : ex_pc_ext + 32'd4;
        end
    end

    // Statistics keep counting through a flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_count_q <= '0;
            mp_count_q <= '0;
        end else begin
            if (ex_valid && (br_count_q != 32'hFFFF_FFFF)) begin
                br_count_q <= br_count_q + 32'd1;
            end
            if (mispredict && (mp_count_q != 32'hFFFF_FFFF)) begin
                mp_count_q <= mp_count_q + 32'd1;
            end
        end
    end

    assign br_count = br_count_q;
    assign mp_count = mp_count_q;

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter PC_W, default 9, SHALL set the program-counter width in bits.
REQ-002 Parameter ENTRIES, default 16, SHALL set the table depth; it SHALL be a power of two and at least 2. IDX_W = log2(ENTRIES) and TAG_W = PC_W-IDX_W-2; PC_W SHALL be at least IDX_W+3.
REQ-003 Ports, listed as name, direction, width, meaning:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- if_pc  in  PC_W  fetch-stage PC for lookup.
- pred_taken  out  1  fetch prediction.
- pred_target  out  32  predicted target, zero-extended.
- ex_valid  in  1  resolved control-flow instruction present in EX.
- ex_pc  in  PC_W  PC of the resolved instruction.
- ex_is_jump  in  1  instruction is JAL/JALR.
- ex_taken  in  1  actual outcome; SHALL be 1 whenever ex_is_jump=1.
- ex_target  in  32  actual target.
- ex_pred_taken  in  1  prediction carried down the pipe.
- ex_pred_target  in  32  prediction carried down the pipe.
- flush_tbl  in  1  invalidate the whole table.
- mispredict  out  1  redirect required.
- redirect_pc  out  32  correct next PC.
- br_count  out  32  resolved control-flow instructions.
- mp_count  out  32  mispredictions.

Function
REQ-004 Table index SHALL be pc[IDX_W+1:2] and tag SHALL be pc[PC_W-1:IDX_W+2]. Each entry SHALL hold: valid, tag, 2-bit counter, target[PC_W-1:0].
REQ-005 Lookup SHALL be combinational. A hit is valid AND tag match.
- pred_taken = hit AND counter[1].
- pred_target = zero-extended stored target when hit, else 0.
REQ-006 Counter encoding SHALL be SNT=0, WNT=1, WT=2, ST=3.
- Saturating increment on taken, decrement on not-taken.
- No wrap at 0 or 3.
REQ-007 Update SHALL occur at the clock edge when ex_valid=1, according to the following cases:
- Hit, conditional branch: counter steps per REQ-006; target overwritten with ex_target[PC_W-1:0] when taken.
- Hit, jump: counter forced to ST; target overwritten.
- Miss, taken: entry allocated (replacing the occupant) with valid=1, new tag, target, counter=WT (ST for jumps).
- Miss, not taken: no table change.
REQ-008 mispredict SHALL be combinational:
- mispredict = ex_valid AND ((ex_taken XOR ex_pred_taken) OR (ex_taken AND ex_target != ex_pred_target)).
- mispredict SHALL be 0 when ex_valid=0.
REQ-009 redirect_pc SHALL be ex_target when ex_taken=1, else zero-extended ex_pc + 4 computed in 32 bits. It SHALL be 0 when ex_valid=0.
REQ-010 Lookup and update to the same index in the same cycle: the lookup SHALL return pre-update contents, with no bypass. The update SHALL be visible from the next cycle.
REQ-011 flush_tbl=1 SHALL clear all valid bits at the edge. Flush SHALL take priority over a same-cycle update, which is dropped. Statistics counters SHALL still count that instruction.
REQ-012 Statistics counters SHALL behave as follows:
- br_count increments by 1 per ex_valid cycle.
- mp_count increments by 1 per mispredict cycle.
- Both saturate at 32'hFFFF_FFFF.
REQ-013 Prediction latency to fetch SHALL be 0 cycles. Update-to-visible latency SHALL be 1 cycle.

Reset
REQ-014 At a clock edge with rst_n=0, the following SHALL hold:
- All valid bits = 0 and all counters = WNT.
- Stored tags and targets = 0.
- br_count = 0 and mp_count = 0.
REQ-015 Consequently, pred_taken=0 and pred_target=0 for any if_pc from the cycle after reset.
REQ-016 Reset SHALL take priority over flush_tbl and over any update. A reset asserted mid-update SHALL discard that update.

Structure
REQ-017 The shared package SHALL hold the 2-bit counter enum (SNT/WNT/WT/ST) and the entry struct typedef.
REQ-018 The saturating 2-bit counter next-state logic SHALL be a sub-module named sat_counter2. It SHALL be purely combinational, with inputs cur and taken and output nxt.
REQ-019 The table SHALL be flop-based, not an inferred RAM, so that flush works in one cycle.

Verification
REQ-020 Reset then lookup: rst_n=0 for 2 cycles, then if_pc=0x040 -> pred_taken=0, pred_target=0, br_count=0.
REQ-021 Training: branch at ex_pc=0x010 taken to ex_target=0x080, repeated over 3 resolves. Expected response:
- After resolve 1: lookup 0x010 gives pred_taken=1 and pred_target=0x080 (WT).
- After resolves 2 and 3: counter at ST.
- Then 2 not-taken resolves give pred_taken=0 (WNT).
REQ-022 Alias: train 0x010, then resolve a taken branch at 0x050 (same index, different tag, PC_W=9, ENTRIES=16). Expected response:
- The entry is replaced.
- Lookup 0x010 gives pred_taken=0.
- Lookup 0x050 gives pred_taken=1.
REQ-023 Mispredict: ex_valid=1, ex_taken=0, ex_pred_taken=1, ex_pc=0x1FC -> mispredict=1, redirect_pc=0x200 (no truncation).
REQ-024 Wrong target on JALR: ex_is_jump=1, ex_target=0x0A0, ex_pred_target=0x0C0 -> mispredict=1, redirect_pc=0x0A0, table target updated to 0x0A0.
REQ-025 Flush collision: flush_tbl=1 with a same-cycle taken update at 0x020 -> all lookups miss next cycle, br_count still increments.
